// File: rtl/uart_tx_fifo_if.sv
// Handshake bundle between byte producers, the TX FIFO and the UART transmitter.
// The slave modport is the FIFO side; the master modport is the producer/transmitter side.
interface uart_tx_fifo_if #(
    parameter int DEPTH_LOG2 = 4,
    parameter int DATA_W     = 8
);
    logic [DATA_W-1:0]   wr_data;
    logic                wr_en;
    logic                full;
    logic                empty;
    logic [DEPTH_LOG2:0] count;
    logic [DATA_W-1:0]   tx_data;
    logic                tx_valid;
    logic                tx_ready;
    logic                ovf;

    modport slave (
        input  wr_data, wr_en, tx_ready,
        output full, empty, count, tx_data, tx_valid, ovf
    );

    modport master (
        output wr_data, wr_en, tx_ready,
        input  full, empty, count, tx_data, tx_valid, ovf
    );
endinterface

// File: rtl/uart_tx_fifo.sv
// Byte FIFO ahead of the UART transmitter; pops one byte per transmitter frame as a one-cycle valid pulse.
// Optional sticky overflow flag and saturating drop counter under UART_TX_FIFO_OVF_EN.
//
// state      | meaning
// S_IDLE     | waiting for data and transmitter idle (ready high); pops on entry condition
// S_PRESENT  | popped byte loaded into tx_data; schedules the single valid pulse
// S_WAIT_ACK | valid pulse out; waits for ready low (byte accepted)
module uart_tx_fifo #(
    parameter int DEPTH_LOG2 = 4,
    parameter int DATA_W     = 8
) (
    input  logic          clk,
    input  logic          rst,
    uart_tx_fifo_if.slave bus
);
    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam int CNT_W = DEPTH_LOG2 + 1;

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_PRESENT  = 2'd1,
        S_WAIT_ACK = 2'd2
    } state_t;

    state_t                state_q, state_d;
    logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d;
    logic [DEPTH_LOG2-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]      count_q, count_d;
    logic                  full_q, full_d;
    logic                  empty_q, empty_d;
    logic [DATA_W-1:0]     tx_data_q, tx_data_d;
    logic                  tx_valid_q, tx_valid_d;
    logic [DATA_W-1:0]     mem_q [DEPTH];
    logic                  push;
    logic                  pop;

    // full is the registered value, so a write is refused even if a pop lands in the same cycle
    assign push = bus.wr_en && !full_q;

    always_comb begin
        state_d    = state_q;
        rd_ptr_d   = rd_ptr_q;
        wr_ptr_d   = wr_ptr_q;
        tx_data_d  = tx_data_q;
        tx_valid_d = 1'b0;
        pop        = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (!empty_q && bus.tx_ready) begin
                    pop       = 1'b1;
                    tx_data_d = mem_q[rd_ptr_q];
                    rd_ptr_d  = rd_ptr_q + DEPTH_LOG2'(1);
                    state_d   = S_PRESENT;
                end
            end
            S_PRESENT: begin
                tx_valid_d = 1'b1;
                state_d    = S_WAIT_ACK;
            end
            S_WAIT_ACK: begin
                if (!bus.tx_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (push) begin
            wr_ptr_d = wr_ptr_q + DEPTH_LOG2'(1);
        end

        case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase

        full_d  = (count_d == CNT_W'(DEPTH));
        empty_d = (count_d == '0);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= S_IDLE;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            full_q     <= 1'b0;
            empty_q    <= 1'b1;
            tx_data_q  <= '0;
            tx_valid_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            full_q     <= full_d;
            empty_q    <= empty_d;
            tx_data_q  <= tx_data_d;
            tx_valid_q <= tx_valid_d;
        end
    end

    // Storage needs no reset: occupancy alone decides what is readable
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= bus.wr_data;
        end
    end

    assign bus.full     = full_q;
    assign bus.empty    = empty_q;
    assign bus.count    = count_q;
    assign bus.tx_data  = tx_data_q;
    assign bus.tx_valid = tx_valid_q;

`ifdef UART_TX_FIFO_OVF_EN
    logic       ovf_q, ovf_d;
    logic [7:0] drop_cnt_q, drop_cnt_d;

    always_comb begin
        ovf_d      = ovf_q;
        drop_cnt_d = drop_cnt_q;
        if (bus.wr_en && full_q) begin
            ovf_d = 1'b1;
            if (drop_cnt_q != 8'hFF) begin
                drop_cnt_d = drop_cnt_q + 8'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ovf_q      <= 1'b0;
            drop_cnt_q <= '0;
        end else begin
            ovf_q      <= ovf_d;
            drop_cnt_q <= drop_cnt_d;
        end
    end

    assign bus.ovf = ovf_q;
`else
    assign bus.ovf = 1'b0;
`endif
endmodule

// File: doc/uart_tx_fifo.md
Name: uart_tx_fifo

Overview:
Byte FIFO sitting directly upstream of the UART transmitter, so producers (CPU store port, debug logger) can burst bytes without tracking line timing. Buffers up to 2**DEPTH_LOG2 bytes. Feeds the transmitter one byte at a time through a single-cycle valid pulse, paced by the transmitter's ready level.

Parameters:
DEPTH_LOG2, 4, log2 of FIFO depth (default 16 entries)
DATA_W, 8, byte width; must match transmitter data width

Ports:
clk  input  1  system clock
rst  input  1  asynchronous reset, active-low
wr_data  input  DATA_W  byte to enqueue
wr_en  input  1  enqueue strobe, one byte per cycle while high
full  output  1  FIFO holds 2**DEPTH_LOG2 entries
empty  output  1  FIFO holds 0 entries
count  output  DEPTH_LOG2+1  current occupancy
tx_data  output  DATA_W  byte presented to transmitter
tx_valid  output  1  one-cycle pulse: tx_data is valid
tx_ready  input  1  transmitter ready level (high = idle, low = busy)
ovf  output  1  sticky overflow flag (see Optional Feature)

Behaviour:
- Reset (rst=0, async): rd/wr pointers=0, count=0, empty=1, full=0, tx_valid=0, tx_data=0, ovf=0, FSM=S_IDLE. Reset mid-transfer discards all stored bytes; no partial pulse may follow reset release.
- Storage: circular buffer with DEPTH_LOG2-bit pointers that wrap naturally (entry 15 -> 0 at default). full/empty/count are registered and derived from count.
- Write: wr_en=1 with full=0 stores wr_data at wr_ptr, wr_ptr+1. wr_en=1 with full=1 drops the byte; pointers and count are unchanged. full is evaluated on the registered value, so a write is rejected when full even if a pop occurs in the same cycle.
- Simultaneous push and pop while not full: both occur and count is unchanged.
- Read FSM (registered outputs):
  S_IDLE: tx_valid=0. If empty=0 and tx_ready=1: pop. tx_data<=mem[rd_ptr], rd_ptr+1, count-1. Next state S_PRESENT.
  S_PRESENT: tx_valid=1 for exactly this cycle. Next state S_WAIT_ACK.
  S_WAIT_ACK: tx_valid=0. Stay until tx_ready=0 (transmitter accepted the byte). Then go to S_IDLE, which waits for tx_ready=1 again before the next pop.
- Latency: the first byte written into an empty FIFO with tx_ready=1 gives tx_valid=1 three cycles after the wr_en edge (write, pop, present).
- tx_valid is never high for two consecutive cycles. The transmitter re-sends a byte on a held valid, so this rule is mandatory.
- tx_data holds its last value outside S_PRESENT.
- tx_ready held at 0 from reset (the transmitter's ready reset value is 0): the FSM stays in S_IDLE and bytes accumulate.
- Throughput: one byte per transmitter frame. The FIFO never limits line rate.

Optional Feature:
Macro UART_TX_FIFO_OVF_EN.
- Defined: ovf is set on any cycle with wr_en=1 and full=1. It stays high until rst. An internal 8-bit saturating drop counter (holds at 255) is also exposed as a hierarchical signal for debug.
- Not defined: ovf is tied to 0, no counter logic is built, and dropped-write behaviour is otherwise identical.

Test Plan:
- Reset, tx_ready=1, write 0x55 once -> tx_valid pulses 1 cycle with tx_data=0x55 three cycles later; empty=1, count=0 afterwards.
- Write 0x41,0x42,0x43 back-to-back, model transmitter with ready low for 10 cycles after each valid -> exactly three single-cycle pulses in order 0x41,0x42,0x43; no duplicate pulses.
- tx_ready=0, write 17 bytes 0x00..0x10 -> full=1 and count=16 after the 16th write; 0x10 dropped; with OVF_EN, ovf=1. Release ready -> 0x00..0x0F delivered in order.
- Fill to 16, then push 0xAA in the same cycle a pop occurs -> push rejected (full registered), count=15 afterwards.
- Wrap check: stream 40 bytes through continuously -> output sequence identical to input across pointer wrap at entry 15->0.
- Assert rst low while in S_WAIT_ACK with 5 bytes queued -> count=0, empty=1, tx_valid=0 immediately; no pulse after release until new writes.
